wshb_arbiter: RTL

Two-requester Wishbone arbiter sharing the single SDRAM controller port between the VGA frame reader (requester 0) and a second bus master (requester 1, e.g. a frame writer or CPU bridge). It sits between those masters and the SDRAM Wishbone slave, all in the Wishbone clock domain. It grants the bus per Wishbone cycle (cyc envelope), forwards one owner's signals, and routes ack/read data back only to that owner. A burst limit keeps the VGA reader from monopolising the bus while its FIFO refills.

---
 rtl/wshb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter: grants the SDRAM port per cyc envelope, with a burst limit
// so the VGA reader cannot starve requester 1. Define ARB_ROUND_ROBIN_EN for round-robin contention.
module wshb_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int ADR_W     = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             s0_cyc,
  input  logic             s0_stb,
  input  logic             s0_we,
  input  logic [ADR_W-1:0] s0_adr,
  input  logic [3:0]       s0_sel,
  input  logic [31:0]      s0_dat_ms,
  input  logic [2:0]       s0_cti,
  input  logic [1:0]       s0_bte,
  output logic             s0_ack,
  output logic [31:0]      s0_dat_sm,

  input  logic             s1_cyc,
  input  logic             s1_stb,
  input  logic             s1_we,
  input  logic [ADR_W-1:0] s1_adr,
  input  logic [3:0]       s1_sel,
  input  logic [31:0]      s1_dat_ms,
  input  logic [2:0]       s1_cti,
  input  logic [1:0]       s1_bte,
  output logic             s1_ack,
  output logic [31:0]      s1_dat_sm,

  output logic             m_cyc,
  output logic             m_stb,
  output logic             m_we,
  output logic [ADR_W-1:0] m_adr,
  output logic [3:0]       m_sel,
  output logic [31:0]      m_dat_ms,
  output logic [2:0]       m_cti,
  output logic [1:0]       m_bte,
  input  logic             m_ack,
  input  logic [31:0]      m_dat_sm,

  output logic [1:0]       gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam bit PREEMPT_EN = (MAX_BURST > 0);
  localparam int CNT_W      = PREEMPT_EN ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREEMPT_EN ? MAX_BURST - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             preempt;
  logic             next_pref;   // requester owed the next grant after a preemption
  logic             rr_last;     // requester served by the most recent grant

  logic own_is_1;
  logic own_cyc;
  logic other_cyc;
  logic burst_end;
  logic idle_pick;

  assign own_is_1  = (state == OWN1);
  assign own_cyc   = own_is_1 ? s1_cyc : s0_cyc;
  assign other_cyc = own_is_1 ? s0_cyc : s1_cyc;
  assign burst_end = PREEMPT_EN && m_ack && (burst_cnt == CNT_LAST) && other_cyc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idle_pick = s1_cyc;
    if (s0_cyc && s1_cyc) begin
      if (preempt)    idle_pick = next_pref;
      else if (RR_EN) idle_pick = ~rr_last;
      else            idle_pick = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      burst_cnt <= '0;
      preempt   <= 1'b0;
      next_pref <= 1'b0;
      rr_last   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_cyc || s1_cyc) begin
            state     <= idle_pick ? OWN1 : OWN0;
            gnt       <= idle_pick ? 2'b10 : 2'b01;
            rr_last   <= idle_pick;
            preempt   <= 1'b0;
            burst_cnt <= '0;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end else if (burst_end) begin
            // Owner keeps cyc/stb asserted and simply sees wait states until re-granted.
            state     <= IDLE;
            gnt       <= 2'b00;
            preempt   <= 1'b1;
            next_pref <= ~own_is_1;
          end else if (m_ack && (burst_cnt != CNT_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Request mux; the owner's stb is masked simply by IDLE forcing m_stb low.
  always_comb begin
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    s0_ack   = 1'b0;
    s1_ack   = 1'b0;
    m_we     = own_is_1 ? s1_we     : s0_we;
    m_adr    = own_is_1 ? s1_adr    : s0_adr;
    m_sel    = own_is_1 ? s1_sel    : s0_sel;
    m_dat_ms = own_is_1 ? s1_dat_ms : s0_dat_ms;
    m_cti    = own_is_1 ? s1_cti    : s0_cti;
    m_bte    = own_is_1 ? s1_bte    : s0_bte;
    case (state)
      OWN0: begin
        m_cyc  = s0_cyc;
        m_stb  = s0_stb;
        s0_ack = m_ack;
      end
      OWN1: begin
        m_cyc  = s1_cyc;
        m_stb  = s1_stb;
        s1_ack = m_ack;
      end
      default: ;
    endcase
  end

  assign s0_dat_sm = m_dat_sm;
  assign s1_dat_sm = m_dat_sm;

endmodule
